// File: rtl/pe_pkg.sv
// Shared constants, accumulator state encoding and lane helper for the pe_acc slice.
package pe_pkg;

    localparam int LANES     = 32;
    localparam int PROD_W    = 32;
    localparam int TREE_LVLS = 5;
    localparam int TREE_W    = PROD_W + TREE_LVLS;

    typedef enum logic {
        ACC_IDLE = 1'b0,
        ACC_RUN  = 1'b1
    } acc_state_t;

    function automatic logic [PROD_W-1:0] lane_slice(
        input logic [LANES*PROD_W-1:0] vec,
        input int unsigned             idx
    );
        return vec[idx*PROD_W +: PROD_W];
    endfunction

endpackage

// File: rtl/pe_add_level.sv
// One registered level of the reduction tree: N signed IN_W-bit inputs summed
// pairwise into N/2 sign-extended (IN_W+1)-bit outputs, with valid/last alongside.
module pe_add_level #(
    parameter int N    = 32,
    parameter int IN_W = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        en,
    input  logic                        valid,
    input  logic                        last,
    input  logic [N*IN_W-1:0]           data,
    output logic                        sum_valid,
    output logic                        sum_last,
    output logic [(N/2)*(IN_W+1)-1:0]   sum
);

    localparam int SUM_W = IN_W + 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_valid <= 1'b0;
            sum_last  <= 1'b0;
        end else if (en) begin
            sum_valid <= valid;
            sum_last  <= last;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N/2; gi++) begin : g_pair
            logic [IN_W-1:0]  a;
            logic [IN_W-1:0]  b;
            logic [SUM_W-1:0] pair_reg;

            assign a = data[(2*gi)*IN_W   +: IN_W];
            assign b = data[(2*gi+1)*IN_W +: IN_W];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pair_reg <= '0;
                end else if (en) begin
                    pair_reg <= {a[IN_W-1], a} + {b[IN_W-1], b};
                end
            end

            assign sum[gi*SUM_W +: SUM_W] = pair_reg;
        end
    endgenerate

endmodule

// File: rtl/pe_acc.sv
// Dot-product stage: 5-level registered adder tree over 32 int32 lanes, packet
// accumulator and valid/ready result register. PE_ACC_SAT_EN selects saturating narrowing.
module pe_acc
    import pe_pkg::*;
#(
    parameter int ACC_W = 48,
    parameter int OUT_W = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      mult_valid,
    output logic                      mult_ready,
    input  logic                      mult_last,
    input  logic [LANES*PROD_W-1:0]   mult_result,
    output logic                      acc_valid,
    input  logic                      acc_ready,
    output logic [OUT_W-1:0]          acc_result
);

    logic en;
    logic accept;

    assign en         = ~(acc_valid & ~acc_ready);
    assign mult_ready = en;
    assign accept     = mult_valid & en;

    genvar gi;
    generate
        for (gi = 0; gi < TREE_LVLS; gi++) begin : g_lvl
            localparam int N    = LANES >> gi;
            localparam int IN_W = PROD_W + gi;

            logic [N*IN_W-1:0]          data;
            logic                       valid;
            logic                       last;
            logic [(N/2)*(IN_W+1)-1:0]  sum;
            logic                       sum_valid;
            logic                       sum_last;

            if (gi == 0) begin : g_src
                assign data  = mult_result;
                assign valid = accept;
                assign last  = mult_last;
            end else begin : g_chain
                assign data  = g_lvl[gi-1].sum;
                assign valid = g_lvl[gi-1].sum_valid;
                assign last  = g_lvl[gi-1].sum_last;
            end

            pe_add_level #(
                .N    (N),
                .IN_W (IN_W)
            ) u_level (
                .clk       (clk),
                .rst_n     (rst_n),
                .en        (en),
                .valid     (valid),
                .last      (last),
                .data      (data),
                .sum_valid (sum_valid),
                .sum_last  (sum_last),
                .sum       (sum)
            );
        end
    endgenerate

    logic [TREE_W-1:0] tree_sum;
    logic              tree_valid;
    logic              tree_last;

    assign tree_sum   = g_lvl[TREE_LVLS-1].sum;
    assign tree_valid = g_lvl[TREE_LVLS-1].sum_valid;
    assign tree_last  = g_lvl[TREE_LVLS-1].sum_last;

    acc_state_t        state_reg, state_next;
    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic              res_valid_reg, res_valid_next;
    logic [OUT_W-1:0]  res_reg, res_next;

    logic [ACC_W-1:0]  sum_ext;
    logic [ACC_W-1:0]  final_val;
    logic [OUT_W-1:0]  narrowed;

    assign sum_ext   = {{(ACC_W-TREE_W){tree_sum[TREE_W-1]}}, tree_sum};
    // In IDLE the accumulator is zero by construction, so the sum alone is the total.
    assign final_val = (state_reg == ACC_RUN) ? acc_reg + sum_ext : sum_ext;

`ifdef PE_ACC_SAT_EN
    logic [ACC_W-OUT_W:0] final_hi;

    assign final_hi = final_val[ACC_W-1:OUT_W-1];

    always_comb begin
        narrowed = final_val[OUT_W-1:0];
        if (!((&final_hi) || (~|final_hi))) begin
            narrowed = final_val[ACC_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                          : {1'b0, {(OUT_W-1){1'b1}}};
        end
    end
`else
    logic unused_final_hi;

    assign narrowed        = final_val[OUT_W-1:0];
    assign unused_final_hi = ^final_val[ACC_W-1:OUT_W];
`endif

    always_comb begin
        state_next     = state_reg;
        acc_next       = acc_reg;
        res_valid_next = res_valid_reg;
        res_next       = res_reg;
        if (en) begin
            if (res_valid_reg && acc_ready) begin
                res_valid_next = 1'b0;
            end
            if (tree_valid) begin
                if (tree_last) begin
                    res_valid_next = 1'b1;
                    res_next       = narrowed;
                    acc_next       = '0;
                    state_next     = ACC_IDLE;
                end else begin
                    acc_next       = final_val;
                    state_next     = ACC_RUN;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ACC_IDLE;
            acc_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            acc_reg       <= acc_next;
            res_valid_reg <= res_valid_next;
            res_reg       <= res_next;
        end
    end

    assign acc_valid  = res_valid_reg;
    assign acc_result = res_reg;

endmodule

// File: tb/tb_pe_acc.sv
// Scoreboard bench for pe_acc: directed packets plus randomized traffic and backpressure.
module tb_pe_acc;
    import pe_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic                    mult_valid = 1'b0;
    logic                    mult_last = 1'b0;
    logic [LANES*PROD_W-1:0] mult_result = '0;
    logic                    acc_ready = 1'b1;
    logic                    mult_ready;
    logic                    acc_valid;
    logic [31:0]             acc_result;

    pe_acc dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mult_valid  (mult_valid),
        .mult_ready  (mult_ready),
        .mult_last   (mult_last),
        .mult_result (mult_result),
        .acc_valid   (acc_valid),
        .acc_ready   (acc_ready),
        .acc_result  (acc_result)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [47:0] m_acc = '0;
    bit          rand_ready = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, want, $time);
        end else begin
            $display("ok   %s value=%h t=%0t", name, act, $time);
        end
    endtask

    function automatic logic [LANES*PROD_W-1:0] fill(input logic [31:0] v);
        logic [LANES*PROD_W-1:0] r;
        for (int i = 0; i < LANES; i++) r[i*PROD_W +: PROD_W] = v;
        return r;
    endfunction

    // Reference: plain signed sum of all lanes, modulo 2^48.
    function automatic logic [47:0] beat_sum(input logic [LANES*PROD_W-1:0] v);
        longint s = 0;
        for (int i = 0; i < LANES; i++) s += $signed(lane_slice(v, i));
        return s[47:0];
    endfunction

    function automatic logic [31:0] narrow(input logic [47:0] a);
`ifdef PE_ACC_SAT_EN
        longint sv;
        sv = $signed({{16{a[47]}}, a});
        if (sv > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (sv < -64'sd2147483648) return 32'h8000_0000;
        return a[31:0];
`else
        return a[31:0];
`endif
    endfunction

    // Drive one beat, wait (bounded) for acceptance, then update the model.
    task automatic send_beat(input logic [LANES*PROD_W-1:0] d, input bit last,
                             input bit use_want, input logic [31:0] want);
        bit rdy = 1'b0;
        int n = 0;
        mult_valid  = 1'b1;
        mult_result = d;
        mult_last   = last;
        do begin
            @(negedge clk);
            rdy = mult_ready;
            @(posedge clk);
            n++;
        end while (!rdy && n < 1000);
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=no_accept required=accept t=%0t", $time);
        end else begin
            m_acc = m_acc + beat_sum(d);
            if (last) begin
                exp_q.push_back(use_want ? want : narrow(m_acc));
                m_acc = '0;
            end
        end
        #1;
        mult_valid = 1'b0;
        mult_last  = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Monitor: pops the scoreboard on each handshake and checks hold while stalled.
    logic [31:0] held;
    bit          holding = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            holding = 1'b0;
        end else begin
            if (holding && acc_valid) check("stall_hold", acc_result, held);
            if (acc_valid && acc_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h required=none t=%0t", acc_result, $time);
                end else begin
                    check("result", acc_result, exp_q.pop_front());
                end
                holding = 1'b0;
            end else if (acc_valid) begin
                holding = 1'b1;
                held    = acc_result;
            end else begin
                holding = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 acc_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #400000;
        checks++;
        errors++;
        $display("FAIL global_timeout actual=running required=finished");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        logic [LANES*PROD_W-1:0] v;
        int n;

        repeat (3) @(posedge clk);
        #1;
        check("reset_acc_valid", acc_valid, 0);
        check("reset_acc_result", acc_result, 0);
        check("reset_mult_ready", mult_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single beat lane i = i; latency from accept edge to acc_valid.
        for (int i = 0; i < LANES; i++) v[i*PROD_W +: PROD_W] = i;
        send_beat(v, 1'b1, 1'b1, 32'd496);
        n = 0;
        while (!acc_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_edges", n, 5);
        drain();

        // Back-to-back packets: 3 beats of 1s, then one beat of 2s.
        send_beat(fill(32'd1), 1'b0, 1'b0, 32'd0);
        send_beat(fill(32'd1), 1'b0, 1'b0, 32'd0);
        send_beat(fill(32'd1), 1'b1, 1'b1, 32'd96);
        send_beat(fill(32'd2), 1'b1, 1'b1, 32'd64);
        drain();

        // Negative values.
        send_beat(fill(32'hFFFF_FFFF), 1'b0, 1'b0, 32'd0);
        send_beat(fill(32'hFFFF_FFFF), 1'b1, 1'b1, 32'hFFFF_FFC0);
        drain();

        // Overflow beyond the 32-bit result range.
`ifdef PE_ACC_SAT_EN
        send_beat(fill(32'h7FFF_FFFF), 1'b1, 1'b1, 32'h7FFF_FFFF);
`else
        send_beat(fill(32'h7FFF_FFFF), 1'b1, 1'b1, 32'hFFFF_FFE0);
`endif
        drain();

        // Backpressure with a queued final sum and a blocked third packet.
        acc_ready = 1'b0;
        send_beat(fill(32'd5), 1'b1, 1'b1, 32'd160);
        for (int i = 0; i < LANES; i++) v[i*PROD_W +: PROD_W] = 2 * i;
        send_beat(v, 1'b1, 1'b1, 32'd992);
        fork
            send_beat(fill(32'd1), 1'b1, 1'b1, 32'd32);
            begin
                n = 0;
                while (!acc_valid && n < 20) begin
                    @(posedge clk);
                    #1;
                    n++;
                end
                repeat (4) begin
                    @(posedge clk);
                    #1;
                    check("stall_mult_ready", mult_ready, 0);
                end
                acc_ready = 1'b1;
                @(posedge clk);
                #1;
                check("same_edge_valid", acc_valid, 1);
            end
        join
        drain();

        // Reset in the middle of a 4-beat packet.
        send_beat(fill(32'd7), 1'b0, 1'b0, 32'd0);
        send_beat(fill(32'd9), 1'b0, 1'b0, 32'd0);
        #2;
        rst_n = 1'b0;
        m_acc = '0;
        #1;
        check("midreset_acc_valid", acc_valid, 0);
        check("midreset_mult_ready", mult_ready, 1);
        check("midreset_acc_result", acc_result, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_beat(fill(32'd3), 1'b1, 1'b1, 32'd96);
        drain();

        // Randomized packets, bubbles and consumer backpressure.
        rand_ready = 1'b1;
        for (int p = 0; p < 40; p++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int b = 0; b < len; b++) begin
                for (int i = 0; i < LANES; i++) v[i*PROD_W +: PROD_W] = $urandom;
                send_beat(v, (b == len - 1), 1'b0, 32'd0);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 3)) @(posedge clk);
                    #1;
                end
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #2;
        acc_ready = 1'b1;
        drain();
        check("queue_empty", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
